// File: rtl/move_referee.sv
// Gomoku referee: owns the authoritative board maps, alternates human (black) and AI (white)
// turns, and walks a sequential five-in-a-row scan around every newly placed stone.
module move_referee #(
    parameter int BOARD_N = 15,
    parameter int WIN_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   choose_row,
    input  logic [3:0]                   choose_col,
    input  logic                         pressed,
    input  logic [3:0]                   ai_row,
    input  logic [3:0]                   ai_col,
    input  logic                         ai_valid,
    output logic                         is_player,
    output logic                         have_chess,
    output logic [BOARD_N*BOARD_N-1:0]   black_map,
    output logic [BOARD_N*BOARD_N-1:0]   white_map,
    output logic [3:0]                   last_row,
    output logic [3:0]                   last_col,
    output logic [7:0]                   move_count,
    output logic                         busy,
    output logic                         ai_reject,
    output logic                         game_over,
    output logic [1:0]                   winner
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam logic [3:0]        N4 = 4'(BOARD_N);
    localparam logic signed [5:0] N6 = 6'(BOARD_N);

    typedef enum logic [1:0] {WAIT_P, WAIT_A, SCAN, OVER} state_t;

    state_t             state_q, state_d;
    logic [CELLS-1:0]   black_q, black_d, white_q, white_d;
    logic [3:0]         last_row_q, last_row_d, last_col_q, last_col_d;
    logic [7:0]         count_q, count_d;
    logic               pressed_q;
    logic               ai_reject_q, ai_reject_d;
    logic [1:0]         winner_q, winner_d;
    logic               white_turn_q, white_turn_d;
    logic [1:0]         dir_q, dir_d;
    logic               side_q, side_d;
    logic [3:0]         k_q, k_d;
    logic [3:0]         cnt_q, cnt_d;

    function automatic logic [7:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
        return 8'(r * BOARD_N + c);
    endfunction

    logic [CELLS-1:0] occ;
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_occ
        assign occ[gi] = black_q[gi] | white_q[gi];
    end

    logic       cur_in, cur_occ, ai_in, ai_occ;
    logic [7:0] cur_idx, ai_idx;

    assign cur_in  = (choose_row < N4) && (choose_col < N4);
    assign cur_idx = cell_idx(choose_row, choose_col);
    assign cur_occ = cur_in ? occ[cur_idx] : 1'b0;
    assign ai_in   = (ai_row < N4) && (ai_col < N4);
    assign ai_idx  = cell_idx(ai_row, ai_col);
    assign ai_occ  = ai_in ? occ[ai_idx] : 1'b0;

    // Neighbour under test: last + k*dir, negated on the minus side.
    logic signed [5:0] dr, dc, k6, step_r, step_c, nr, nc;
    logic              nb_in, nb_hit;
    logic [7:0]        nb_idx;

    always_comb begin
        dr = 6'sd1;
        dc = 6'sd0;
        case (dir_q)
            2'd0: begin dr = 6'sd0; dc = 6'sd1;  end
            2'd1: begin dr = 6'sd1; dc = 6'sd0;  end
            2'd2: begin dr = 6'sd1; dc = 6'sd1;  end
            default: begin dr = 6'sd1; dc = -6'sd1; end
        endcase
        k6     = $signed({2'b00, k_q});
        step_r = side_q ? -(dr * k6) : dr * k6;
        step_c = side_q ? -(dc * k6) : dc * k6;
        nr     = $signed({2'b00, last_row_q}) + step_r;
        nc     = $signed({2'b00, last_col_q}) + step_c;
        nb_in  = (nr >= 6'sd0) && (nr < N6) && (nc >= 6'sd0) && (nc < N6);
        nb_idx = cell_idx(nr[3:0], nc[3:0]);
        nb_hit = nb_in && (white_turn_q ? white_q[nb_idx] : black_q[nb_idx]);
    end

    logic side_end;

    always_comb begin
        state_d      = state_q;
        black_d      = black_q;
        white_d      = white_q;
        last_row_d   = last_row_q;
        last_col_d   = last_col_q;
        count_d      = count_q;
        ai_reject_d  = 1'b0;
        winner_d     = winner_q;
        white_turn_d = white_turn_q;
        dir_d        = dir_q;
        side_d       = side_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        side_end     = 1'b0;

        case (state_q)
            WAIT_P: begin
                if (pressed && !pressed_q && cur_in && !cur_occ) begin
                    black_d[cur_idx] = 1'b1;
                    last_row_d   = choose_row;
                    last_col_d   = choose_col;
                    count_d      = count_q + 8'd1;
                    white_turn_d = 1'b0;
                    dir_d        = 2'd0;
                    side_d       = 1'b0;
                    k_d          = 4'd1;
                    cnt_d        = 4'd1;
                    state_d      = SCAN;
                end
            end
            WAIT_A: begin
                if (ai_valid) begin
                    if (ai_in && !ai_occ) begin
                        white_d[ai_idx] = 1'b1;
                        last_row_d   = ai_row;
                        last_col_d   = ai_col;
                        count_d      = count_q + 8'd1;
                        white_turn_d = 1'b1;
                        dir_d        = 2'd0;
                        side_d       = 1'b0;
                        k_d          = 4'd1;
                        cnt_d        = 4'd1;
                        state_d      = SCAN;
                    end else begin
                        ai_reject_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (nb_hit) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 >= 4'(WIN_LEN)) begin
                        winner_d = white_turn_q ? 2'b10 : 2'b01;
                        state_d  = OVER;
                    end else if (k_q == 4'(WIN_LEN - 1)) begin
                        side_end = 1'b1;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end else begin
                    side_end = 1'b1;
                end

                // cnt carries over from the plus side into the minus side of a direction.
                if (side_end) begin
                    k_d = 4'd1;
                    if (!side_q) begin
                        side_d = 1'b1;
                    end else if (dir_q != 2'd3) begin
                        side_d = 1'b0;
                        dir_d  = dir_q + 2'd1;
                        cnt_d  = 4'd1;
                    end else if (count_q == 8'(CELLS)) begin
                        winner_d = 2'b11;
                        state_d  = OVER;
                    end else begin
                        state_d = white_turn_q ? WAIT_P : WAIT_A;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_P;
            black_q      <= '0;
            white_q      <= '0;
            last_row_q   <= 4'd7;
            last_col_q   <= 4'd7;
            count_q      <= 8'd0;
            pressed_q    <= 1'b0;
            ai_reject_q  <= 1'b0;
            winner_q     <= 2'b00;
            white_turn_q <= 1'b0;
            dir_q        <= 2'd0;
            side_q       <= 1'b0;
            k_q          <= 4'd1;
            cnt_q        <= 4'd1;
        end else begin
            state_q      <= state_d;
            black_q      <= black_d;
            white_q      <= white_d;
            last_row_q   <= last_row_d;
            last_col_q   <= last_col_d;
            count_q      <= count_d;
            pressed_q    <= pressed;
            ai_reject_q  <= ai_reject_d;
            winner_q     <= winner_d;
            white_turn_q <= white_turn_d;
            dir_q        <= dir_d;
            side_q       <= side_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
        end
    end

    assign is_player  = (state_q == WAIT_P);
    assign have_chess = (state_q != WAIT_P) | ~cur_in | cur_occ;
    assign black_map  = black_q;
    assign white_map  = white_q;
    assign last_row   = last_row_q;
    assign last_col   = last_col_q;
    assign move_count = count_q;
    assign busy       = (state_q == SCAN);
    assign ai_reject  = ai_reject_q;
    assign game_over  = (state_q == OVER);
    assign winner     = winner_q;

endmodule

// File: tb/tb_move_referee.sv
// Directed bench for move_referee: a move table with hand-computed outcomes plus
// hand-written sequences for first-move scan length, held key and asynchronous reset.
module tb_move_referee;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   choose_row, choose_col, ai_row, ai_col;
    logic         pressed, ai_valid;
    logic         is_player, have_chess, busy, ai_reject, game_over;
    logic [224:0] black_map, white_map;
    logic [3:0]   last_row, last_col;
    logic [7:0]   move_count;
    logic [1:0]   winner;

    always #5 clk = ~clk;

    move_referee dut (
        .clk(clk), .rst(rst),
        .choose_row(choose_row), .choose_col(choose_col), .pressed(pressed),
        .ai_row(ai_row), .ai_col(ai_col), .ai_valid(ai_valid),
        .is_player(is_player), .have_chess(have_chess),
        .black_map(black_map), .white_map(white_map),
        .last_row(last_row), .last_col(last_col), .move_count(move_count),
        .busy(busy), .ai_reject(ai_reject), .game_over(game_over), .winner(winner)
    );

    typedef struct {
        bit         rst_first;
        bit         ai;
        logic [3:0] r;
        logic [3:0] c;
        bit         acc;
        bit         rej;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad = 0;

    // Reference board state, advanced only by moves the table says are accepted.
    logic [224:0] m_black, m_white;
    int           m_count;
    logic [3:0]   m_lr, m_lc;
    int           m_turn;   // 0 human, 1 AI, 2 over

    task automatic chk(input string nm, input logic [224:0] act, input logic [224:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_black = '0;
        m_white = '0;
        m_count = 0;
        m_lr    = 4'd7;
        m_lc    = 4'd7;
        m_turn  = 0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        pressed = 1'b0;
        ai_valid = 1'b0;
        choose_row = 4'd7;
        choose_col = 4'd7;
        ai_row = 4'd0;
        ai_col = 4'd0;
        tick;
        tick;
        rst = 1'b0;
        model_reset;
    endtask

    task automatic check_state(input string tag, input logic [1:0] exp_win);
        chk({tag, "_black"}, black_map, m_black);
        chk({tag, "_white"}, white_map, m_white);
        chk({tag, "_count"}, move_count, 225'(m_count));
        chk({tag, "_lrow"}, last_row, m_lr);
        chk({tag, "_lcol"}, last_col, m_lc);
        chk({tag, "_isplayer"}, is_player, m_turn == 0);
        chk({tag, "_over"}, game_over, m_turn == 2);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_winner"}, winner, exp_win);
    endtask

    task automatic wait_scan(input string tag);
        int cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            tick;
            cyc++;
        end
        chk({tag, "_scan_ended"}, busy, 1'b0);
        chk({tag, "_scan_le32"}, cyc <= 32, 1'b1);
    endtask

    task automatic apply(input vec_t v, input string tag);
        int idx;
        bit in_rng;
        in_rng = (v.r < 15) && (v.c < 15);
        idx = int'(v.r) * 15 + int'(v.c);
        if (!v.ai) begin
            choose_row = v.r;
            choose_col = v.c;
            pressed = 1'b0;
            #1;
            chk({tag, "_havechess"}, have_chess,
                (m_turn != 0) || !in_rng || (in_rng && (m_black[idx] || m_white[idx])));
            tick;
            pressed = 1'b1;
            tick;
        end else begin
            ai_row = v.r;
            ai_col = v.c;
            ai_valid = 1'b1;
            tick;
            ai_valid = 1'b0;
            chk({tag, "_rej"}, ai_reject, v.rej);
        end
        if (v.acc) begin
            chk({tag, "_busy_start"}, busy, 1'b1);
            if (v.ai) m_white[idx] = 1'b1;
            else      m_black[idx] = 1'b1;
            m_count++;
            m_lr = v.r;
            m_lc = v.c;
            wait_scan(tag);
            m_turn = (v.win != 2'b00) ? 2 : (v.ai ? 0 : 1);
        end else if (v.ai) begin
            tick;
            chk({tag, "_rej_end"}, ai_reject, 1'b0);
        end
        check_state(tag, v.win);
    endtask

    function automatic void add(input int rf, input int ai, input int r, input int c,
                                input int acc, input int rej, input int win);
        vec_t v;
        v.rst_first = rf[0];
        v.ai        = ai[0];
        v.r         = r[3:0];
        v.c         = c[3:0];
        v.acc       = acc[0];
        v.rej       = rej[0];
        v.win       = win[1:0];
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t v;
        int   cyc;

        // rst, ai, row, col, accepted, reject pulse, winner afterwards
        add(0, 1, 7, 7, 0, 1, 0);
        add(0, 1, 15, 0, 0, 1, 0);
        add(0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 15, 3, 0, 0, 0);
        add(0, 0, 7, 7, 0, 0, 0);
        add(0, 0, 7, 3, 1, 0, 0);
        add(0, 1, 0, 1, 1, 0, 0);
        add(0, 0, 7, 4, 1, 0, 0);
        add(0, 1, 0, 2, 1, 0, 0);
        add(0, 0, 7, 6, 1, 0, 0);
        add(0, 1, 0, 3, 1, 0, 0);
        add(0, 0, 7, 5, 1, 0, 1);
        add(0, 0, 8, 8, 0, 0, 1);
        add(0, 1, 9, 9, 0, 0, 1);
        add(1, 0, 0, 11, 1, 0, 0);
        add(0, 1, 0, 4, 1, 0, 0);
        add(0, 0, 0, 12, 1, 0, 0);
        add(0, 1, 1, 3, 1, 0, 0);
        add(0, 0, 0, 13, 1, 0, 0);
        add(0, 1, 2, 2, 1, 0, 0);
        add(0, 0, 0, 14, 1, 0, 0);
        add(0, 1, 3, 1, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0);
        add(0, 1, 4, 0, 1, 0, 2);

        do_reset;
        check_state("reset", 2'b00);
        chk("reset_havechess", have_chess, 1'b0);
        $display("txn reset: is_player=%0b count=%0d", is_player, move_count);

        // First stone at the centre, key held: every side ends on its first empty neighbour.
        choose_row = 4'd7;
        choose_col = 4'd7;
        tick;
        pressed = 1'b1;
        tick;
        chk("first_bit112", black_map[112], 1'b1);
        chk("first_busy", busy, 1'b1);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) cyc++;
            tick;
        end
        chk("first_scan_len", cyc, 8);
        m_black[112] = 1'b1;
        m_count = 1;
        m_turn = 1;
        check_state("first", 2'b00);
        $display("txn first move (7,7): scan=%0d count=%0d", cyc, move_count);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst_first) do_reset;
            apply(v, $sformatf("v%0d", i));
            $display("txn v%0d %s (%0d,%0d): count=%0d winner=%0d over=%0b",
                     i, v.ai ? "ai" : "player", v.r, v.c, move_count, winner, game_over);
        end

        // Asynchronous reset in the middle of a scan, with no clock edge.
        do_reset;
        choose_row = 4'd7;
        choose_col = 4'd7;
        tick;
        pressed = 1'b1;
        tick;
        chk("async_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        pressed = 1'b0;
        #1;
        model_reset;
        check_state("async", 2'b00);
        tick;
        rst = 1'b0;
        v.rst_first = 1'b0; v.ai = 1'b0; v.r = 4'd3; v.c = 4'd3;
        v.acc = 1'b1; v.rej = 1'b0; v.win = 2'b00;
        apply(v, "resume");
        $display("txn async reset then (3,3): count=%0d is_player=%0b", move_count, is_player);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
